// File: rtl/axi_datamover_mm2s_lite_if.sv
// Bundle of the command, status, AXI read and MM2S stream signals of the lite datamover.
// The master modport is the datamover's view; slave is the view of the surrounding system.
interface axi_datamover_mm2s_lite_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 64,
   parameter int unsigned CMD_W  = 73,
   parameter int unsigned STS_W  = 8
);
   localparam int unsigned KEEP_W = DATA_W / 8;

   logic              S_AXIS_CMD_TVALID;
   logic              S_AXIS_CMD_TREADY;
   logic [CMD_W-1:0]  S_AXIS_CMD_TDATA;

   logic              M_AXIS_STS_TVALID;
   logic              M_AXIS_STS_TREADY;
   logic [STS_W-1:0]  M_AXIS_STS_TDATA;

   logic [ADDR_W-1:0] M_AXI_ARADDR;
   logic [7:0]        M_AXI_ARLEN;
   logic [2:0]        M_AXI_ARSIZE;
   logic [1:0]        M_AXI_ARBURST;
   logic              M_AXI_ARVALID;
   logic              M_AXI_ARREADY;

   logic [DATA_W-1:0] M_AXI_RDATA;
   logic [1:0]        M_AXI_RRESP;
   logic              M_AXI_RLAST;
   logic              M_AXI_RVALID;
   logic              M_AXI_RREADY;

   logic [DATA_W-1:0] M_AXIS_MM2S_TDATA;
   logic [KEEP_W-1:0] M_AXIS_MM2S_TKEEP;
   logic              M_AXIS_MM2S_TLAST;
   logic              M_AXIS_MM2S_TVALID;
   logic              M_AXIS_MM2S_TREADY;

   modport master (
      input  S_AXIS_CMD_TVALID, S_AXIS_CMD_TDATA, M_AXIS_STS_TREADY,
             M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
             M_AXIS_MM2S_TREADY,
      output S_AXIS_CMD_TREADY, M_AXIS_STS_TVALID, M_AXIS_STS_TDATA,
             M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
             M_AXI_RREADY, M_AXIS_MM2S_TDATA, M_AXIS_MM2S_TKEEP, M_AXIS_MM2S_TLAST,
             M_AXIS_MM2S_TVALID
   );

   modport slave (
      output S_AXIS_CMD_TVALID, S_AXIS_CMD_TDATA, M_AXIS_STS_TREADY,
             M_AXI_ARREADY, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST, M_AXI_RVALID,
             M_AXIS_MM2S_TREADY,
      input  S_AXIS_CMD_TREADY, M_AXIS_STS_TVALID, M_AXIS_STS_TDATA,
             M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST, M_AXI_ARVALID,
             M_AXI_RREADY, M_AXIS_MM2S_TDATA, M_AXIS_MM2S_TKEEP, M_AXIS_MM2S_TLAST,
             M_AXIS_MM2S_TVALID
   );
endinterface

// File: rtl/axi_datamover_mm2s_lite.sv
// Lite MM2S datamover: turns one linear read command into 4 KB-safe AXI4 INCR bursts,
// streams the read data out and returns one status byte per command.
module axi_datamover_mm2s_lite #(
   parameter int unsigned C_M_AXI_ADDR_WIDTH      = 32,
   parameter int unsigned C_M_AXI_DATA_WIDTH      = 64,
   parameter int unsigned C_S_AXIS_CMD_DATA_WIDTH = 73,
   parameter int unsigned C_M_AXIS_STS_DATA_WIDTH = 8,
   parameter int unsigned C_MAX_BURST_LEN         = 16
) (
   input logic clk,
   input logic rst,
   axi_datamover_mm2s_lite_if.master bus
);
   localparam int unsigned ADDR_W  = C_M_AXI_ADDR_WIDTH;
   localparam int unsigned KEEP_W  = C_M_AXI_DATA_WIDTH / 8;
   localparam int unsigned BTT_W   = 23;
   localparam int unsigned BEATS_W = 21;
   localparam int unsigned LEN_W   = 9;
   localparam int unsigned TAG_W   = 4;

   typedef enum logic [2:0] {IDLE, CHECK, ADDR, DATA, STS} state_t;

   state_t                             state;
   logic [BTT_W-1:0]                   btt;
   logic                               eof;
   logic [ADDR_W-1:0]                  saddr;
   logic [TAG_W-1:0]                   tag;
   logic [BEATS_W-1:0]                 beats_left;
   logic [ADDR_W-1:0]                  cur_addr;
   logic [LEN_W-1:0]                   burst_len;
   logic [LEN_W-1:0]                   beat_cnt;
   logic                               slverr;
   logic                               decerr;
   logic                               interr;
   logic                               cmd_tready;
   logic                               ar_valid;
   logic [ADDR_W-1:0]                  ar_addr;
   logic [7:0]                         ar_len;
   logic                               sts_valid;
   logic [C_M_AXIS_STS_DATA_WIDTH-1:0] sts_data;

   logic               in_data;
   logic               beat_hs;
   logic               final_beat;
   logic               burst_done;
   logic [8:0]         keep_wide;
   logic [BEATS_W-1:0] to_page;
   logic [BEATS_W-1:0] len_calc;
   logic               unused_bits;

   // Next burst length: remaining beats capped by max burst size and the 4 KB page end
   always_comb begin
      to_page  = BEATS_W'(10'd512 - {1'b0, cur_addr[11:3]});
      len_calc = beats_left;
      if (len_calc > BEATS_W'(C_MAX_BURST_LEN)) len_calc = BEATS_W'(C_MAX_BURST_LEN);
      if (len_calc > to_page) len_calc = to_page;
   end

   assign in_data    = (state == DATA);
   assign beat_hs    = in_data && bus.M_AXI_RVALID && bus.M_AXIS_MM2S_TREADY;
   assign final_beat = (beats_left == BEATS_W'(1));
   assign burst_done = (beat_cnt == burst_len - LEN_W'(1));
   assign keep_wide  = (9'd1 << btt[2:0]) - 9'd1;

   assign unused_bits = ^{bus.S_AXIS_CMD_TDATA[C_S_AXIS_CMD_DATA_WIDTH-1:68],
                          bus.S_AXIS_CMD_TDATA[31], bus.S_AXIS_CMD_TDATA[29:23]};

   assign bus.S_AXIS_CMD_TREADY = cmd_tready;
   assign bus.M_AXIS_STS_TVALID = sts_valid;
   assign bus.M_AXIS_STS_TDATA  = sts_data;
   assign bus.M_AXI_ARADDR      = ar_addr;
   assign bus.M_AXI_ARLEN       = ar_len;
   assign bus.M_AXI_ARSIZE      = 3'b011;
   assign bus.M_AXI_ARBURST     = 2'b01;
   assign bus.M_AXI_ARVALID     = ar_valid;

   // Read channel is a straight pass-through onto the stream while a burst is in flight
   assign bus.M_AXI_RREADY       = in_data && bus.M_AXIS_MM2S_TREADY;
   assign bus.M_AXIS_MM2S_TVALID = in_data && bus.M_AXI_RVALID;
   assign bus.M_AXIS_MM2S_TDATA  = bus.M_AXI_RDATA;
   assign bus.M_AXIS_MM2S_TKEEP  = (in_data && final_beat && (btt[2:0] != 3'd0))
                                   ? KEEP_W'(keep_wide[7:0]) : {KEEP_W{1'b1}};
   assign bus.M_AXIS_MM2S_TLAST  = in_data && final_beat && eof;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         btt        <= '0;
         eof        <= 1'b0;
         saddr      <= '0;
         tag        <= '0;
         beats_left <= '0;
         cur_addr   <= '0;
         burst_len  <= '0;
         beat_cnt   <= '0;
         slverr     <= 1'b0;
         decerr     <= 1'b0;
         interr     <= 1'b0;
         cmd_tready <= 1'b0;
         ar_valid   <= 1'b0;
         ar_addr    <= '0;
         ar_len     <= '0;
         sts_valid  <= 1'b0;
         sts_data   <= '0;
      end else begin
         case (state)
            IDLE: begin
               cmd_tready <= 1'b1;
               if (cmd_tready && bus.S_AXIS_CMD_TVALID) begin
                  cmd_tready <= 1'b0;
                  btt        <= bus.S_AXIS_CMD_TDATA[22:0];
                  eof        <= bus.S_AXIS_CMD_TDATA[30];
                  saddr      <= bus.S_AXIS_CMD_TDATA[63:32];
                  tag        <= bus.S_AXIS_CMD_TDATA[67:64];
                  state      <= CHECK;
               end
            end
            CHECK: begin
               if ((btt == '0) || (saddr[2:0] != 3'd0)) begin
                  interr <= 1'b1;
                  state  <= STS;
               end else begin
                  beats_left <= BEATS_W'(({1'b0, btt} + 24'd7) >> 3);
                  cur_addr   <= saddr;
                  state      <= ADDR;
               end
            end
            ADDR: begin
               // First cycle loads the request, then it is held until accepted
               if (!ar_valid) begin
                  ar_valid  <= 1'b1;
                  ar_addr   <= cur_addr;
                  ar_len    <= 8'(len_calc - BEATS_W'(1));
                  burst_len <= LEN_W'(len_calc);
                  beat_cnt  <= '0;
               end else if (bus.M_AXI_ARREADY) begin
                  ar_valid <= 1'b0;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (beat_hs) begin
                  beats_left <= beats_left - BEATS_W'(1);
                  beat_cnt   <= beat_cnt + LEN_W'(1);
                  if (bus.M_AXI_RRESP == 2'b10) slverr <= 1'b1;
                  if (bus.M_AXI_RRESP == 2'b11) decerr <= 1'b1;
                  // RLAST out of step with our own beat count is a protocol error; the count wins
                  if (bus.M_AXI_RLAST != burst_done) interr <= 1'b1;
                  if (burst_done) begin
                     if (final_beat) begin
                        state <= STS;
                     end else begin
                        cur_addr <= cur_addr + (ADDR_W'(burst_len) << 3);
                        state    <= ADDR;
                     end
                  end
               end
            end
            STS: begin
               if (!sts_valid) begin
                  sts_valid <= 1'b1;
                  sts_data  <= C_M_AXIS_STS_DATA_WIDTH'({~(slverr | decerr | interr),
                                                         slverr, decerr, interr, tag});
               end else if (bus.M_AXIS_STS_TREADY) begin
                  sts_valid  <= 1'b0;
                  slverr     <= 1'b0;
                  decerr     <= 1'b0;
                  interr     <= 1'b0;
                  cmd_tready <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi_datamover_mm2s_lite.sv
// Randomised bench for axi_datamover_mm2s_lite: a memory slave, stream and status sinks with
// random backpressure, compared against a burst-splitting reference model of each command.
module tb_axi_datamover_mm2s_lite;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   axi_datamover_mm2s_lite_if bus ();
   axi_datamover_mm2s_lite dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct packed {
      logic [31:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
   } ar_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
   } beat_t;

   int          n_chk = 0;
   int          n_err = 0;
   logic [72:0] cmd_q[$];
   ar_t         ar_obs[$];
   beat_t       beat_obs[$];
   logic [7:0]  sts_obs[$];
   int          err_beat = -1;
   logic [1:0]  err_resp = 2'b00;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_word(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, a + 32'h1234_5678};
   endfunction

   // Bus agent: samples handshakes on the falling edge, updates and drives just after the rising edge
   initial begin
      logic        in_rst, ar_hs, r_hs, s_hs, st_hs, c_hs, serving;
      ar_t         ar_s;
      beat_t       bt_s;
      logic [7:0]  st_s;
      logic [31:0] s_addr;
      int          s_len, s_idx, g_idx;
      serving = 1'b0; s_addr = '0; s_len = 0; s_idx = 0; g_idx = 0;
      bus.S_AXIS_CMD_TVALID  = 1'b0;
      bus.S_AXIS_CMD_TDATA   = '0;
      bus.M_AXIS_STS_TREADY  = 1'b0;
      bus.M_AXI_ARREADY      = 1'b0;
      bus.M_AXI_RDATA        = '0;
      bus.M_AXI_RRESP        = 2'b00;
      bus.M_AXI_RLAST        = 1'b0;
      bus.M_AXI_RVALID       = 1'b0;
      bus.M_AXIS_MM2S_TREADY = 1'b0;
      forever begin
         @(negedge clk);
         in_rst = rst;
         ar_hs  = bus.M_AXI_ARVALID && bus.M_AXI_ARREADY;
         r_hs   = bus.M_AXI_RVALID && bus.M_AXI_RREADY;
         s_hs   = bus.M_AXIS_MM2S_TVALID && bus.M_AXIS_MM2S_TREADY;
         st_hs  = bus.M_AXIS_STS_TVALID && bus.M_AXIS_STS_TREADY;
         c_hs   = bus.S_AXIS_CMD_TVALID && bus.S_AXIS_CMD_TREADY;
         ar_s   = '{bus.M_AXI_ARADDR, bus.M_AXI_ARLEN, bus.M_AXI_ARSIZE, bus.M_AXI_ARBURST};
         bt_s   = '{bus.M_AXIS_MM2S_TDATA, bus.M_AXIS_MM2S_TKEEP, bus.M_AXIS_MM2S_TLAST};
         st_s   = bus.M_AXIS_STS_TDATA;
         @(posedge clk);
         #1;
         if (in_rst) begin
            serving = 1'b0; g_idx = 0;
            bus.S_AXIS_CMD_TVALID = 1'b0;
            bus.M_AXI_RVALID      = 1'b0;
            bus.M_AXI_RLAST       = 1'b0;
            bus.M_AXI_RDATA       = '0;
            bus.M_AXI_RRESP       = 2'b00;
            continue;
         end
         if (c_hs && cmd_q.size() != 0) begin
            void'(cmd_q.pop_front());
            g_idx = 0;
         end
         if (ar_hs) begin
            ar_obs.push_back(ar_s);
            serving = 1'b1; s_addr = ar_s.addr; s_len = int'(ar_s.len); s_idx = 0;
         end
         if (s_hs) beat_obs.push_back(bt_s);
         if (r_hs) begin
            s_idx++; g_idx++;
            if (s_idx > s_len) serving = 1'b0;
         end
         if (st_hs) sts_obs.push_back(st_s);
         bus.S_AXIS_CMD_TVALID = (cmd_q.size() != 0);
         bus.S_AXIS_CMD_TDATA  = (cmd_q.size() != 0) ? cmd_q[0] : '0;
         if (!serving) begin
            bus.M_AXI_RVALID = 1'b0;
            bus.M_AXI_RLAST  = 1'b0;
         end else if (!bus.M_AXI_RVALID || r_hs) begin
            bus.M_AXI_RVALID = ($urandom % 4) != 0;
            bus.M_AXI_RDATA  = mem_word(s_addr + 32'(s_idx * 8));
            bus.M_AXI_RLAST  = (s_idx == s_len);
            bus.M_AXI_RRESP  = (g_idx == err_beat) ? err_resp : 2'b00;
         end
         bus.M_AXI_ARREADY      = ($urandom % 2) != 0;
         bus.M_AXIS_MM2S_TREADY = ($urandom % 4) != 0;
         bus.M_AXIS_STS_TREADY  = ($urandom % 3) != 0;
      end
   end

   // Reference model of one command plus comparison of everything observed for it
   task automatic run_cmd(input logic [31:0] saddr, input logic [22:0] btt, input logic eof,
                          input logic [3:0] tag, input int eb, input logic [1:0] er);
      ar_t        exp_ar[$];
      beat_t      exp_bt[$];
      logic [7:0] exp_st;
      logic [72:0] cmd;
      int nb, rem, ln, to4k, r, n;
      logic [31:0] a;
      logic slv, dec;
      if (btt == 0 || saddr[2:0] != 3'd0) begin
         exp_st = {4'b0001, tag};
      end else begin
         nb = (int'(btt) + 7) / 8;
         a = saddr; rem = nb;
         while (rem > 0) begin
            to4k = (4096 - int'(a[11:0])) / 8;
            ln = rem;
            if (ln > 16) ln = 16;
            if (ln > to4k) ln = to4k;
            exp_ar.push_back('{a, 8'(ln - 1), 3'b011, 2'b01});
            a = a + 32'(ln * 8);
            rem = rem - ln;
         end
         r = int'(btt) % 8;
         for (int i = 0; i < nb; i++)
            exp_bt.push_back('{mem_word(saddr + 32'(i * 8)),
                               (i == nb - 1 && r != 0) ? 8'((1 << r) - 1) : 8'hFF,
                               eof && (i == nb - 1)});
         slv = (er == 2'b10) && eb >= 0 && eb < nb;
         dec = (er == 2'b11) && eb >= 0 && eb < nb;
         exp_st = {~(slv | dec), slv, dec, 1'b0, tag};
      end
      err_beat = eb;
      err_resp = er;
      ar_obs.delete(); beat_obs.delete(); sts_obs.delete();
      cmd = {5'($urandom), tag, saddr, 1'($urandom), eof, 6'($urandom), 1'($urandom), btt};
      cmd_q.push_back(cmd);
      for (int c = 0; c < 20000 && sts_obs.size() == 0; c++) @(posedge clk);
      chk("sts_arrived", 64'(sts_obs.size() != 0), 64'd1);
      if (sts_obs.size() != 0) chk("status", 64'(sts_obs[0]), 64'(exp_st));
      chk("ar_count", 64'(ar_obs.size()), 64'(exp_ar.size()));
      n = (ar_obs.size() < exp_ar.size()) ? ar_obs.size() : exp_ar.size();
      for (int i = 0; i < n; i++) chk($sformatf("ar[%0d]", i), 64'(ar_obs[i]), 64'(exp_ar[i]));
      chk("beat_count", 64'(beat_obs.size()), 64'(exp_bt.size()));
      n = (beat_obs.size() < exp_bt.size()) ? beat_obs.size() : exp_bt.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("beat[%0d].data", i), beat_obs[i].data, exp_bt[i].data);
         chk($sformatf("beat[%0d].keep_last", i), 64'({beat_obs[i].keep, beat_obs[i].last}),
             64'({exp_bt[i].keep, exp_bt[i].last}));
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, ".cmd_tready"}, 64'(bus.S_AXIS_CMD_TREADY), 64'd0);
      chk({tag, ".arvalid"},    64'(bus.M_AXI_ARVALID), 64'd0);
      chk({tag, ".rready"},     64'(bus.M_AXI_RREADY), 64'd0);
      chk({tag, ".tvalid"},     64'(bus.M_AXIS_MM2S_TVALID), 64'd0);
      chk({tag, ".tlast"},      64'(bus.M_AXIS_MM2S_TLAST), 64'd0);
      chk({tag, ".sts_valid"},  64'(bus.M_AXIS_STS_TVALID), 64'd0);
      chk({tag, ".sts_data"},   64'(bus.M_AXIS_STS_TDATA), 64'd0);
   endtask

   initial begin
      logic [31:0] ra;
      logic [22:0] rb;
      int          nb, eb;
      repeat (3) @(posedge clk);
      #1;
      chk_idle_outputs("reset");
      #1 rst = 1'b0;

      run_cmd(32'h0000_1000, 23'd64, 1'b1, 4'd3, -1, 2'b00);
      run_cmd(32'h0000_2000, 23'd300, 1'b1, 4'd7, -1, 2'b00);
      run_cmd(32'h0000_0FF0, 23'd64, 1'b1, 4'd1, -1, 2'b00);
      run_cmd(32'h0000_3000, 23'd0, 1'b1, 4'd5, -1, 2'b00);
      run_cmd(32'h0000_1004, 23'd64, 1'b1, 4'd5, -1, 2'b00);
      run_cmd(32'h0000_4000, 23'd32, 1'b0, 4'd9, 2, 2'b10);
      run_cmd(32'h0000_5FF8, 23'd17, 1'b1, 4'd12, 1, 2'b11);
      run_cmd(32'h0000_6000, 23'd1, 1'b1, 4'd15, -1, 2'b00);

      for (int k = 0; k < 16; k++) begin
         ra = 32'($urandom) & 32'h000F_FFF8;
         if ($urandom % 10 == 0) ra[1:0] = 2'($urandom_range(1, 3));
         rb = ($urandom % 12 == 0) ? 23'd0 : 23'($urandom_range(1, 700));
         nb = (int'(rb) + 7) / 8;
         eb = ($urandom % 3 == 0 && nb > 0) ? int'($urandom_range(0, nb - 1)) : -1;
         run_cmd(ra, rb, 1'($urandom), 4'($urandom), eb, ($urandom % 2 != 0) ? 2'b10 : 2'b11);
      end

      // Abort a long transfer mid-stream, then confirm the next command runs clean
      err_beat = -1;
      beat_obs.delete();
      cmd_q.push_back({5'd0, 4'd2, 32'h0000_7000, 1'b0, 1'b1, 6'd0, 1'b0, 23'd2000});
      for (int c = 0; c < 5000 && beat_obs.size() < 5; c++) @(posedge clk);
      chk("abort_reached_data", 64'(beat_obs.size() >= 5), 64'd1);
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      chk_idle_outputs("abort");
      repeat (2) @(posedge clk);
      cmd_q.delete();
      #2 rst = 1'b0;
      run_cmd(32'h0000_1000, 23'd64, 1'b1, 4'd3, -1, 2'b00);
      chk("no_stray_status", 64'(sts_obs.size()), 64'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/axi_datamover_mm2s_lite.md
Name: axi_datamover_mm2s_lite

Overview:
- Responder end of the datamover command/status interface driven by the stream command master.
- Accepts 73-bit datamover commands and converts each into one or more AXI4 read bursts on a memory-mapped master port.
- Forwards the returned read data on an AXI4-Stream output, then returns one 8-bit status word per command.
- Sits between the stream command master and the HP/ACP port, replacing the vendor MM2S datamover for simple linear transfers.

Parameters:
- C_M_AXI_ADDR_WIDTH, 32, AXI read address width.
- C_M_AXI_DATA_WIDTH, 64, read data / stream width; fixed at 64 (8 bytes per beat).
- C_S_AXIS_CMD_DATA_WIDTH, 73, command width; bit 72 ignored.
- C_M_AXIS_STS_DATA_WIDTH, 8, status width.
- C_MAX_BURST_LEN, 16, maximum beats per AXI burst (1..256).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- S_AXIS_CMD_TVALID  in  1  command valid
- S_AXIS_CMD_TREADY  out  1  command ready
- S_AXIS_CMD_TDATA  in  73  command word
- M_AXIS_STS_TVALID  out  1  status valid
- M_AXIS_STS_TREADY  in  1  status ready
- M_AXIS_STS_TDATA  out  8  status word
- M_AXI_ARADDR  out  32  burst address
- M_AXI_ARLEN  out  8  beats-1
- M_AXI_ARSIZE  out  3  constant 3'b011
- M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
- M_AXI_ARVALID  out  1  address valid
- M_AXI_ARREADY  in  1  address ready
- M_AXI_RDATA  in  64  read data
- M_AXI_RRESP  in  2  read response
- M_AXI_RLAST  in  1  last beat of burst
- M_AXI_RVALID  in  1  read valid
- M_AXI_RREADY  out  1  read ready
- M_AXIS_MM2S_TDATA  out  64  stream data
- M_AXIS_MM2S_TKEEP  out  8  byte enables
- M_AXIS_MM2S_TLAST  out  1  end of packet
- M_AXIS_MM2S_TVALID  out  1  stream valid
- M_AXIS_MM2S_TREADY  in  1  stream ready

Behaviour:
- Command fields: BTT=[22:0]; EOF=[30]; SADDR=[63:32]; TAG=[67:64]. Bits [23], [29:24], [31], [72:68] are ignored.
- Status format: {OKAY, SLVERR, DECERR, INTERR, TAG[3:0]}.
- FSM states: IDLE, CHECK, ADDR, DATA, STS. Reset enters IDLE.
- Reset values: all VALID outputs 0, RREADY 0, CMD_TREADY 0, status register 0, counters 0.
- IDLE: CMD_TREADY=1. On handshake, latch the command and go to CHECK. CMD_TREADY=0 in every other state, so only one command is in flight.
- CHECK (1 cycle):
  - If BTT==0 or SADDR[2:0]!=0, set INTERR and go to STS; no AXI traffic is issued.
  - Otherwise set beats_left=ceil(BTT/8) (21-bit) and cur_addr=SADDR, then go to ADDR.
- ADDR: burst length is min(beats_left, C_MAX_BURST_LEN, beats to the next 4 KB boundary).
  - Drive ARADDR=cur_addr and ARLEN=len-1, holding ARVALID=1 until ARREADY.
  - On handshake go to DATA. Only one burst is outstanding at a time.
- DATA: RREADY=MM2S_TREADY, MM2S_TVALID=RVALID, TDATA=RDATA, all combinational pass-through. On each beat handshake decrement beats_left.
  - TKEEP=8'hFF except on the final beat of the command, where TKEEP has (BTT mod 8) low bits set, or FF if BTT mod 8 is 0.
  - TLAST=1 only on the final beat of the command and only when EOF=1.
  - RRESP accumulates into sticky flags: 2'b10 sets SLVERR, 2'b11 sets DECERR. The transfer still completes the full beat count.
  - On the RLAST handshake: if beats_left reaches 0 go to STS, else advance cur_addr by len*8 and go to ADDR.
  - RLAST arriving on a beat other than the expected last sets INTERR; the FSM still finishes on the beat count.
- STS: STS_TVALID=1 with OKAY = no error flag set. Hold until STS_TREADY, then clear flags and go to IDLE.
- Backpressure: MM2S_TREADY low stalls RREADY with no data loss or duplication. STS_TREADY low holds the FSM in STS.
- Reset in any state aborts the transfer immediately; no status is produced for the aborted command.

Test Plan:
- Command SADDR=0x1000, BTT=64, EOF=1, TAG=3, zero-wait memory -> one AR with ARLEN=7, 8 beats, TKEEP=FF, TLAST on beat 8, status 0x83.
- BTT=300 at 0x2000, C_MAX_BURST_LEN=16 -> bursts of 16, 16, 6 beats at 0x2000, 0x2080, 0x2100; last TKEEP=8'h0F; TLAST only on the final beat.
- SADDR=0x0FF0, BTT=64 -> bursts split at 4 KB: 2 beats at 0x0FF0, then 6 beats at 0x1000.
- BTT=0 or SADDR=0x1004, TAG=5 -> no ARVALID, status 0x15.
- RRESP=2'b10 on beat 3 of 4, EOF=0 -> all 4 beats forwarded, TLAST never asserted, status {0100,TAG}.
- Random MM2S_TREADY/STS_TREADY toggling, plus rst asserted mid-DATA -> data matches the memory model; after reset all outputs are 0 and the next command completes normally.
